// File: rtl/filter_scheduler_if.sv
// Purpose: bundles the UART-side, frame-RAM-side and kernel-side signals of
//          the frame-level filter scheduler into one interface.
// Ports (signals):
//   rx_valid, rx_data, mode             environment -> scheduler
//   ld_we, ld_addr, ld_data             input-RAM write port
//   rd_addr, rd_zero                    input-RAM read address / zero-substitute flag
//   col_shift, row_clr                  window register control
//   wr_we, wr_addr                      output-RAM write port
//   mode_lat, busy, frame_done, overrun status
//   dbg_state                           current FSM state, for observation only
// Modports: master = scheduler side, slave = environment side.
interface filter_scheduler_if #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 8
);
    logic              rx_valid;
    logic [DATA_W-1:0] rx_data;
    logic [1:0]        mode;
    logic              ld_we;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_zero;
    logic              col_shift;
    logic              row_clr;
    logic              wr_we;
    logic [ADDR_W-1:0] wr_addr;
    logic [1:0]        mode_lat;
    logic              busy;
    logic              frame_done;
    logic              overrun;
    logic [1:0]        dbg_state;

    modport master (
        input  rx_valid, rx_data, mode,
        output ld_we, ld_addr, ld_data, rd_addr, rd_zero, col_shift, row_clr,
               wr_we, wr_addr, mode_lat, busy, frame_done, overrun, dbg_state
    );

    modport slave (
        output rx_valid, rx_data, mode,
        input  ld_we, ld_addr, ld_data, rd_addr, rd_zero, col_shift, row_clr,
               wr_we, wr_addr, mode_lat, busy, frame_done, overrun, dbg_state
    );
endinterface

// File: rtl/filter_scheduler.sv
// Purpose: frame-level sequencer for the UART-fed 3x3 image filter.
//   Loads received bytes into the input frame RAM, then scans the frame
//   column by column issuing three row reads per column, strobes window
//   shifts and output-RAM writes, and pulses frame_done at the end.
// Ports:
//   clk   - system clock, rising edge
//   RESET - asynchronous, active-high reset
//   bus   - filter_scheduler_if.master (UART input, RAM ports, kernel
//           control, status and debug state)
// Handshake: there is no ready path. rx_valid is a one-cycle strobe and the
//   byte on rx_data is consumed in that same cycle; in FILTER it is dropped
//   and recorded in the sticky overrun flag.
module filter_scheduler #(
    parameter int IMG_W  = 80,
    parameter int IMG_H  = 80,
    parameter int ADDR_W = 13,
    parameter int DATA_W = 8
) (
    input logic                clk,
    input logic                RESET,
    filter_scheduler_if.master bus
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOAD   = 2'd1;
    localparam logic [1:0] S_FILTER = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam int X_W = $clog2(IMG_W + 1);
    localparam int Y_W = $clog2(IMG_H + 1);

    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(IMG_W * IMG_H - 1);
    localparam logic [ADDR_W-1:0] W_A      = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] H_A      = ADDR_W'(IMG_H);
    localparam logic [ADDR_W-1:0] ONE_A    = ADDR_W'(1);
    localparam logic [X_W-1:0]    X_PAD    = X_W'(IMG_W);
    localparam logic [Y_W-1:0]    Y_LAST   = Y_W'(IMG_H - 1);

    logic [1:0]        state;
    logic [ADDR_W-1:0] load_cnt;
    logic [Y_W-1:0]    y;
    logic [X_W-1:0]    x;
    logic [1:0]        p;
    logic              draining;
    logic              drain_cnt;
    logic [1:0]        mode_q;
    logic              overrun_q;

    // Read-return / write pipeline
    logic              zero_q;
    logic              shift_q;
    logic              wr_pend;
    logic [ADDR_W-1:0] wr_addr_pend;
    logic              wr_we_q;
    logic [ADDR_W-1:0] wr_addr_q;

    logic              accept_state;
    logic              ld_fire;
    logic              issuing;
    logic              issue_zero;
    logic [ADDR_W-1:0] row_plus1;
    logic [ADDR_W-1:0] issue_addr;
    logic [ADDR_W-1:0] out_addr;

    always_comb begin
        accept_state = (state == S_IDLE) || (state == S_LOAD) || (state == S_DONE);
        // Reset gates the write strobe so an abort cannot leak a RAM write.
        ld_fire      = accept_state && bus.rx_valid && !RESET;
        issuing      = (state == S_FILTER) && !draining;
        // row_plus1 = (y + p - 1) + 1, kept non-negative so the range test
        // happens before any multiply and nothing can wrap.
        row_plus1    = ADDR_W'(y) + ADDR_W'(p);
        issue_zero   = (row_plus1 == '0) || (row_plus1 > H_A) || (x == X_PAD);
        issue_addr   = issue_zero ? '0 : ((row_plus1 - ONE_A) * W_A + ADDR_W'(x));
        // Output pixel for column x is centred on column x-1.
        out_addr     = ADDR_W'(y) * W_A + ADDR_W'(x) - ONE_A;
    end

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            state        <= S_IDLE;
            load_cnt     <= '0;
            y            <= '0;
            x            <= '0;
            p            <= '0;
            draining     <= 1'b0;
            drain_cnt    <= 1'b0;
            mode_q       <= '0;
            overrun_q    <= 1'b0;
            zero_q       <= 1'b0;
            shift_q      <= 1'b0;
            wr_pend      <= 1'b0;
            wr_addr_pend <= '0;
            wr_we_q      <= 1'b0;
            wr_addr_q    <= '0;
        end else begin
            zero_q  <= issuing && issue_zero;
            shift_q <= issuing && (p == 2'd2);
            wr_pend <= issuing && (p == 2'd2) && (x != '0);
            if (issuing && (p == 2'd2) && (x != '0)) begin
                wr_addr_pend <= out_addr;
            end
            wr_we_q <= wr_pend;
            if (wr_pend) begin
                wr_addr_q <= wr_addr_pend;
            end

            case (state)
                S_IDLE, S_LOAD, S_DONE: begin
                    // DONE lasts one cycle; a byte arriving then starts a new load.
                    if (state == S_DONE) begin
                        state <= S_IDLE;
                    end
                    if (bus.rx_valid) begin
                        if (load_cnt == LAST_PIX) begin
                            state     <= S_FILTER;
                            load_cnt  <= '0;
                            mode_q    <= bus.mode;
                            overrun_q <= 1'b0;
                            y         <= '0;
                            x         <= '0;
                            p         <= '0;
                            draining  <= 1'b0;
                            drain_cnt <= 1'b0;
                        end else begin
                            state    <= S_LOAD;
                            load_cnt <= load_cnt + ONE_A;
                        end
                    end
                end
                S_FILTER: begin
                    if (bus.rx_valid) begin
                        overrun_q <= 1'b1;
                    end
                    if (draining) begin
                        // Two cycles let the last column's shift and write drain.
                        drain_cnt <= 1'b1;
                        if (drain_cnt) begin
                            state    <= S_DONE;
                            draining <= 1'b0;
                        end
                    end else if (p == 2'd2) begin
                        p <= '0;
                        if (x == X_PAD) begin
                            x <= '0;
                            if (y == Y_LAST) begin
                                y         <= '0;
                                draining  <= 1'b1;
                                drain_cnt <= 1'b0;
                            end else begin
                                y <= y + Y_W'(1);
                            end
                        end else begin
                            x <= x + X_W'(1);
                        end
                    end else begin
                        p <= p + 2'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.ld_we      = ld_fire;
        bus.ld_addr    = ld_fire ? load_cnt : '0;
        bus.ld_data    = ld_fire ? bus.rx_data : {DATA_W{1'b0}};
        bus.rd_addr    = issuing ? issue_addr : '0;
        bus.rd_zero    = zero_q;
        bus.col_shift  = shift_q;
        bus.row_clr    = issuing && (x == '0) && (p == 2'd0);
        bus.wr_we      = wr_we_q;
        bus.wr_addr    = wr_addr_q;
        bus.mode_lat   = mode_q;
        bus.busy       = (state == S_LOAD) || (state == S_FILTER);
        bus.frame_done = (state == S_DONE);
        bus.overrun    = overrun_q;
        bus.dbg_state  = state;
    end
endmodule

// File: tb/tb_filter_scheduler.sv
// Purpose: directed self-checking bench for filter_scheduler (80x80 frame).
//   Covers reset values, a full load, the complete filter pass with read
//   order / write addresses / pass length, overrun and mode latching, the
//   DONE-cycle collision, and a mid-run reset.
module tb_filter_scheduler;
    localparam int IMG_W  = 80;
    localparam int IMG_H  = 80;
    localparam int ADDR_W = 13;
    localparam int DATA_W = 8;
    localparam int NPIX   = IMG_W * IMG_H;
    localparam int ISSUES = IMG_H * (IMG_W + 1) * 3;
    localparam int PASS   = ISSUES + 2;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    filter_scheduler_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    filter_scheduler #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W), .DATA_W(DATA_W)
    ) dut (
        .clk  (clk),
        .RESET(rst),
        .bus  (bus)
    );

    int checks = 0;
    int passed = 0;
    int failed = 0;

    int exp_first_addr[6] = '{0, 0, 80, 0, 1, 81};
    int exp_first_zero[6] = '{1, 0, 0, 1, 0, 0};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic [1:0] m);
        @(posedge clk);
        #1;
        bus.rx_valid = v;
        bus.rx_data  = d;
        bus.mode     = m;
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_ld_we"},      32'(bus.ld_we),      0);
        check({pfx, "_ld_addr"},    32'(bus.ld_addr),    0);
        check({pfx, "_ld_data"},    32'(bus.ld_data),    0);
        check({pfx, "_rd_addr"},    32'(bus.rd_addr),    0);
        check({pfx, "_rd_zero"},    32'(bus.rd_zero),    0);
        check({pfx, "_col_shift"},  32'(bus.col_shift),  0);
        check({pfx, "_row_clr"},    32'(bus.row_clr),    0);
        check({pfx, "_wr_we"},      32'(bus.wr_we),      0);
        check({pfx, "_wr_addr"},    32'(bus.wr_addr),    0);
        check({pfx, "_mode_lat"},   32'(bus.mode_lat),   0);
        check({pfx, "_busy"},       32'(bus.busy),       0);
        check({pfx, "_frame_done"}, 32'(bus.frame_done), 0);
        check({pfx, "_overrun"},    32'(bus.overrun),    0);
        check({pfx, "_state"},      32'(bus.dbg_state),  0);
    endtask

    // Issue t of the pass -> row/column/phase and the read it should produce.
    function automatic void issue_info(input int t, output int iy, output int ix, output int ip,
                                       output bit izero, output int iaddr);
        int r;
        iy    = t / ((IMG_W + 1) * 3);
        r     = t % ((IMG_W + 1) * 3);
        ix    = r / 3;
        ip    = r % 3;
        izero = (iy + ip - 1 < 0) || (iy + ip - 1 >= IMG_H) || (ix == IMG_W);
        iaddr = izero ? 0 : (iy + ip - 1) * IMG_W + ix;
    endfunction

    initial begin
        int bad;
        int iy, ix, ip, iaddr;
        bit izero;
        bit exp_zero, exp_shift, w1, w2, prev_lastrow;
        int wa1, wa2;
        int bad_rd, bad_zero, bad_shift, bad_clr, bad_wr, bad_ld, bad_busy;
        int wr_count, wr_nonmono, done_count, done_t, last_row_zero;

        rst          = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = '0;
        bus.mode     = 2'b00;
        repeat (3) @(negedge clk);
        check_all_zero("por");

        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("idle_state", 32'(bus.dbg_state), 0);
        check("idle_busy",  32'(bus.busy),      0);

        // ---------------- frame 1 load ----------------
        bad = 0;
        for (int i = 0; i < NPIX; i++) begin
            step(1'b1, 8'(i % 256), 2'b00);
            if (i == 0) begin
                check("load1_first_we",   32'(bus.ld_we),   1);
                check("load1_first_addr", 32'(bus.ld_addr), 0);
            end
            if (i == NPIX - 1) begin
                check("load1_last_addr",  32'(bus.ld_addr),   NPIX - 1);
                check("load1_last_state", 32'(bus.dbg_state), 1);
            end
            if (bus.ld_we !== 1'b1 || bus.ld_addr !== ADDR_W'(i) || bus.ld_data !== 8'(i % 256)
                || bus.wr_we !== 1'b0 || bus.frame_done !== 1'b0
                || (i > 0 && (bus.busy !== 1'b1 || bus.dbg_state !== 2'd1))) begin
                bad++;
            end
        end
        check("load1_bad_cycles", bad, 0);

        // ---------------- frame 1 filter pass ----------------
        exp_zero = 0; exp_shift = 0; w1 = 0; w2 = 0; wa1 = 0; wa2 = 0; prev_lastrow = 0;
        bad_rd = 0; bad_zero = 0; bad_shift = 0; bad_clr = 0; bad_wr = 0; bad_ld = 0; bad_busy = 0;
        wr_count = 0; wr_nonmono = 0; done_count = 0; done_t = -1; last_row_zero = 0;
        for (int t = 0; t <= PASS; t++) begin
            step((t == 100) || (t == PASS), (t == PASS) ? 8'h00 : 8'hEE,
                 (t >= 100) ? 2'b01 : 2'b00);
            if (t < ISSUES) begin
                issue_info(t, iy, ix, ip, izero, iaddr);
            end else begin
                iy = -1; ix = -1; ip = -1; izero = 0; iaddr = 0;
            end

            if (bus.rd_addr !== ADDR_W'(iaddr)) bad_rd++;
            if (bus.row_clr !== ((t < ISSUES) && ix == 0 && ip == 0)) bad_clr++;
            if (bus.rd_zero !== exp_zero) bad_zero++;
            if (bus.col_shift !== exp_shift) bad_shift++;
            if (bus.wr_we !== w2 || (w2 && bus.wr_addr !== ADDR_W'(wa2))) bad_wr++;
            if (bus.wr_we === 1'b1) begin
                if (bus.wr_addr !== ADDR_W'(wr_count)) wr_nonmono++;
                wr_count++;
            end
            if (prev_lastrow && bus.rd_zero === 1'b1) last_row_zero++;
            if (bus.frame_done === 1'b1) begin
                done_count++;
                done_t = t;
            end
            if (bus.ld_we !== (t == PASS)) bad_ld++;
            if (bus.busy !== (t < PASS)) bad_busy++;

            if (t == 0) begin
                check("filt_entry_state",   32'(bus.dbg_state), 2);
                check("filt_entry_mode",    32'(bus.mode_lat),  0);
                check("filt_entry_overrun", 32'(bus.overrun),   0);
                check("filt_entry_row_clr", 32'(bus.row_clr),   1);
            end
            if (t < 6) check($sformatf("first_rd_addr_%0d", t), 32'(bus.rd_addr), exp_first_addr[t]);
            if (t >= 1 && t <= 6) check($sformatf("first_rd_zero_%0d", t), 32'(bus.rd_zero), exp_first_zero[t-1]);
            if (t == 2) check("col_shift_early", 32'(bus.col_shift), 0);
            if (t == 3) check("col_shift_first", 32'(bus.col_shift), 1);
            if (t == 4) check("no_write_col0",   32'(bus.wr_we),     0);
            if (t == 7) begin
                check("first_wr_we",   32'(bus.wr_we),   1);
                check("first_wr_addr", 32'(bus.wr_addr), 0);
            end
            if (t == 100) check("overrun_no_ld_we", 32'(bus.ld_we), 0);
            if (t == 101) begin
                check("overrun_set",       32'(bus.overrun),  1);
                check("overrun_mode_held", 32'(bus.mode_lat), 0);
            end
            if (t == PASS) begin
                check("done_pulse",        32'(bus.frame_done), 1);
                check("done_coll_ld_we",   32'(bus.ld_we),      1);
                check("done_coll_ld_addr", 32'(bus.ld_addr),    0);
                check("done_overrun_kept", 32'(bus.overrun),    1);
            end

            exp_zero     = (t < ISSUES) && izero;
            exp_shift    = (t < ISSUES) && ip == 2;
            w2           = w1;
            wa2          = wa1;
            w1           = (t < ISSUES) && ip == 2 && ix >= 1;
            wa1          = iy * IMG_W + ix - 1;
            prev_lastrow = (t < ISSUES) && iy == IMG_H - 1 && ip == 2;
        end
        check("pass_rd_addr_errs",  bad_rd,        0);
        check("pass_rd_zero_errs",  bad_zero,      0);
        check("pass_shift_errs",    bad_shift,     0);
        check("pass_row_clr_errs",  bad_clr,       0);
        check("pass_wr_errs",       bad_wr,        0);
        check("pass_ld_we_errs",    bad_ld,        0);
        check("pass_busy_errs",     bad_busy,      0);
        check("pass_wr_count",      wr_count,      NPIX);
        check("pass_wr_nonmono",    wr_nonmono,    0);
        check("pass_done_count",    done_count,    1);
        check("pass_done_time",     done_t,        PASS);
        check("pass_last_row_zero", last_row_zero, IMG_W + 1);

        // ---------------- frame 2 load (address 0 already taken in DONE) ----------------
        bad = 0;
        for (int i = 1; i < NPIX; i++) begin
            step(1'b1, 8'(i % 256), 2'b01);
            if (i == 1) begin
                check("coll_state_load",  32'(bus.dbg_state),  1);
                check("coll_next_addr",   32'(bus.ld_addr),    1);
                check("coll_done_low",    32'(bus.frame_done), 0);
                check("load2_overrun_kept", 32'(bus.overrun),  1);
            end
            if (bus.ld_we !== 1'b1 || bus.ld_addr !== ADDR_W'(i) || bus.dbg_state !== 2'd1) bad++;
        end
        check("load2_bad_cycles", bad, 0);

        // ---------------- frame 2 pass start, then mid-run reset ----------------
        for (int t = 0; t <= 50; t++) begin
            step(1'b0, 8'h00, 2'b10);
            if (t == 0) begin
                check("f2_state",         32'(bus.dbg_state), 2);
                check("f2_mode_latched",  32'(bus.mode_lat),  1);
                check("f2_overrun_clear", 32'(bus.overrun),   0);
            end
            if (t == 40) check("f2_mode_held", 32'(bus.mode_lat), 1);
        end

        @(posedge clk);
        #1;
        rst          = 1'b1;
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h77;
        @(negedge clk);
        check_all_zero("midrst");

        @(posedge clk);
        #1;
        rst          = 1'b0;
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h3C;
        @(negedge clk);
        check("post_rst_ld_we",   32'(bus.ld_we),   1);
        check("post_rst_ld_addr", 32'(bus.ld_addr), 0);
        check("post_rst_ld_data", 32'(bus.ld_data), 32'h3C);
        step(1'b0, 8'h00, 2'b00);
        check("post_rst_state", 32'(bus.dbg_state), 1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
